// File: rtl/adc_rd_pkg.sv
// Shared definitions for the ADC FIFO read-side unpacker.
// ST_HDR only exists when ADC_UNPACK_HEADER_EN is defined.
package adc_rd_pkg;

  localparam int          SLICES_PER_WORD = 8;
  localparam int          SLICE_W         = 32;
  localparam int          FIFO_W          = 256;
  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hA5A5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
`ifdef ADC_UNPACK_HEADER_EN
    ,
    ST_HDR  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/adc_fifo_unpacker_if.sv
// FIFO read port plus the outgoing 32-bit valid/ready stream of the unpacker.
// The slave modport is the unpacker; the master modport is its environment.
interface adc_fifo_unpacker_if;
  import adc_rd_pkg::*;

  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_valid;
  logic [5:0]          fifo_rd_data_cnt;
  logic [FIFO_W-1:0]   fifo_data;
  logic                fifo_rd_en;
  logic [SLICE_W-1:0]  out_data;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  fifo_empty, fifo_full, fifo_valid, fifo_rd_data_cnt, fifo_data,
    output fifo_rd_en,
    output out_data, out_valid,
    input  out_ready
  );

  modport master (
    output fifo_empty, fifo_full, fifo_valid, fifo_rd_data_cnt, fifo_data,
    input  fifo_rd_en,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/adc_rd_flags.sv
// Status flags for the FIFO read side: registered block-ready threshold
// compare and a sticky FIFO-full indicator.
module adc_rd_flags #(
  parameter int BLK_THRESH = 16
) (
  input  logic       rd_clk,
  input  logic       rst_n,
  input  logic       fifo_full,
  input  logic       clr_ovf,
  input  logic [5:0] fifo_rd_data_cnt,
  output logic       blk_ready,
  output logic       ovf_sticky
);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_ready  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      blk_ready <= (fifo_rd_data_cnt >= 6'(BLK_THRESH));
      // A fresh overflow outranks a simultaneous clear.
      if (fifo_full)
        ovf_sticky <= 1'b1;
      else if (clr_ovf)
        ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_fifo_unpacker.sv
// Pops 256-bit ADC words from the FIFO and streams them out as eight 32-bit
// slices, LSB first. ADC_UNPACK_HEADER_EN adds a {HDR_TAG, frame_cnt} word per frame.
module adc_fifo_unpacker
  import adc_rd_pkg::*;
#(
  parameter int          BLK_THRESH  = 16,
  parameter int          FRAME_WORDS = 8,
  parameter logic [15:0] HDR_TAG     = HDR_TAG_DEFAULT
) (
  input  logic                rd_clk,
  input  logic                rst_n,
  adc_fifo_unpacker_if.slave  bus,
  output logic                blk_ready,
  output logic [15:0]         frame_cnt,
  output logic                ovf_sticky,
  input  logic                clr_ovf
);

  localparam int               IDX_W      = $clog2(SLICES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_SLICE = IDX_W'(SLICES_PER_WORD - 1);
  localparam logic [15:0]      LAST_WORD  = 16'(FRAME_WORDS - 1);

  state_t             state;
  state_t             next_state;
  logic [FIFO_W-1:0]  shreg;
  logic [IDX_W-1:0]   slice_idx;
  logic [15:0]        word_idx;
  logic               rd_en;
  logic               valid;
  logic [SLICE_W-1:0] data;
  logic               slice_hs;
  logic               word_done;

  assign slice_hs  = (state == ST_SEND) && bus.out_ready;
  assign word_done = slice_hs && (slice_idx == LAST_SLICE);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // The pop is gated by rst_n so fifo_rd_en reads 0 throughout reset.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    valid      = 1'b0;
    data       = '0;
    case (state)
      ST_IDLE: begin
        if (rst_n && !bus.fifo_empty) begin
          rd_en      = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.fifo_valid) begin
`ifdef ADC_UNPACK_HEADER_EN
          next_state = (word_idx == 16'd0) ? ST_HDR : ST_SEND;
`else
          next_state = ST_SEND;
`endif
        end
      end
`ifdef ADC_UNPACK_HEADER_EN
      ST_HDR: begin
        valid = 1'b1;
        data  = {HDR_TAG, frame_cnt};
        if (bus.out_ready)
          next_state = ST_SEND;
      end
`endif
      ST_SEND: begin
        valid = 1'b1;
        data  = shreg[SLICE_W-1:0];
        if (word_done)
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      slice_idx <= '0;
      word_idx  <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == ST_WAIT && bus.fifo_valid) begin
        shreg     <= bus.fifo_data;
        slice_idx <= '0;
      end else if (slice_hs) begin
        shreg     <= shreg >> SLICE_W;
        slice_idx <= slice_idx + 1'b1;
      end
      if (word_done) begin
        if (word_idx == LAST_WORD) begin
          word_idx  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          word_idx <= word_idx + 16'd1;
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = valid;
  assign bus.out_data   = data;

  adc_rd_flags #(
    .BLK_THRESH(BLK_THRESH)
  ) u_flags (
    .rd_clk           (rd_clk),
    .rst_n            (rst_n),
    .fifo_full        (bus.fifo_full),
    .clr_ovf          (clr_ovf),
    .fifo_rd_data_cnt (bus.fifo_rd_data_cnt),
    .blk_ready        (blk_ready),
    .ovf_sticky       (ovf_sticky)
  );

endmodule

// File: tb/tb_adc_fifo_unpacker.sv
// Scoreboard bench for adc_fifo_unpacker: a queue-based FIFO model feeds the
// DUT, expected slices are queued on push and checked by an independent monitor.
module tb_adc_fifo_unpacker;
  import adc_rd_pkg::*;

  localparam int          FW  = 2;
  localparam int          THR = 16;
  localparam logic [15:0] TAG = 16'hA5A5;

  logic        rd_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        blk_ready;
  logic        ovf_sticky;
  logic [15:0] frame_cnt;

  adc_fifo_unpacker_if bus();

  adc_fifo_unpacker #(
    .BLK_THRESH  (THR),
    .FRAME_WORDS (FW),
    .HDR_TAG     (TAG)
  ) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .blk_ready  (blk_ready),
    .frame_cnt  (frame_cnt),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf)
  );

  always #5 rd_clk = ~rd_clk;

  logic [255:0] fifo_q[$];
  logic [31:0]  exp_q[$];
  int           hs_cycles[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           words_pushed = 0;
  int           ready_mode = 0;
  bit           glitch_en = 0;
  bit           pop_req = 0;

`ifdef ADC_UNPACK_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: each word yields an optional frame header, then its
  // eight 32-bit slices from least significant upward.
  function automatic void push_word(logic [255:0] w);
    if (HDR_ON && (words_pushed % FW == 0))
      exp_q.push_back({TAG, 16'(words_pushed / FW)});
    for (int k = 0; k < 8; k++) exp_q.push_back(w[32*k +: 32]);
    fifo_q.push_back(w);
    words_pushed++;
  endfunction

  initial forever begin
    @(posedge rd_clk);
    cyc++;
  end

  initial begin : ready_driver
    bus.out_ready = 1'b0;
    forever begin
      @(negedge rd_clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // FIFO with one cycle read latency; optional stray fifo_valid pulses.
  initial begin : fifo_model
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    forever begin
      @(negedge rd_clk);
      #1;
      bus.fifo_valid = 1'b0;
      if (!rst_n) begin
        pop_req = 0;
      end else if (pop_req) begin
        check("pop_nonempty", 64'(fifo_q.size() > 0), 64'd1);
        if (fifo_q.size() > 0) begin
          bus.fifo_data  = fifo_q.pop_front();
          bus.fifo_valid = 1'b1;
        end
      end else if (glitch_en && $urandom_range(3) == 0) begin
        bus.fifo_data  = rand_word();
        bus.fifo_valid = 1'b1;
      end
      bus.fifo_empty = (fifo_q.size() == 0);
      #1;
      pop_req = rst_n && bus.fifo_rd_en;
    end
  end

  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_data", 64'(bus.out_data), 64'(prev_data));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_slice", 64'(bus.out_data), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("slice", 64'(bus.out_data), 64'(e));
            hs_cycles.push_back(cyc);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_rd_en"},      64'(bus.fifo_rd_en), 64'd0);
    check({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
    check({tag, "_out_data"},   64'(bus.out_data),   64'd0);
    check({tag, "_blk_ready"},  64'(blk_ready),      64'd0);
    check({tag, "_frame_cnt"},  64'(frame_cnt),      64'd0);
    check({tag, "_ovf_sticky"}, 64'(ovf_sticky),     64'd0);
  endtask

  // Reset with a non-empty FIFO, full flag and high fill count to prove the
  // outputs are all held at zero.
  task automatic applyReset();
    @(negedge rd_clk);
    rst_n = 1'b0;
    bus.fifo_full = 1'b1;
    bus.fifo_rd_data_cnt = 6'd63;
    #3;
    check_zero("rst_now");
    fifo_q.delete();
    exp_q.delete();
    words_pushed = 0;
    fifo_q.push_back({8{32'h5555_AAAA}});
    repeat (3) @(negedge rd_clk);
    #3;
    check_zero("rst_hold");
    fifo_q.delete();
    bus.fifo_full = 1'b0;
    bus.fifo_rd_data_cnt = 6'd0;
    @(negedge rd_clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 800) begin
      @(negedge rd_clk);
      c++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge rd_clk);
    #3;
    check("frame_cnt", 64'(frame_cnt), 64'(16'(words_pushed / FW)));
    check("idle_valid", 64'(bus.out_valid), 64'd0);
  endtask

  // Back-to-back words with out_ready high: 10 cycles per word plus 1 per header.
  task automatic timedRun(int n, bit counting);
    int  t0;
    int  hdrs;
    bit  first_hdr;
    bit  found;
    logic [255:0] w;
    hs_cycles.delete();
    hdrs = 0;
    first_hdr = HDR_ON && (words_pushed % FW == 0);
    for (int i = 0; i < n; i++) begin
      if (HDR_ON && (words_pushed % FW == 0)) hdrs++;
      if (counting) for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'(k + 1);
      else w = rand_word();
      push_word(w);
    end
    found = 0;
    t0 = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge rd_clk);
      #3;
      if (bus.fifo_rd_en) begin
        found = 1;
        t0 = cyc;
      end
    end
    check("pop_seen", 64'(found), 64'd1);
    drain();
    check("hs_count", 64'(hs_cycles.size()), 64'(8 * n + hdrs));
    if (found && hs_cycles.size() > 0) begin
      check("first_latency", 64'(hs_cycles[0] - t0), 64'(2 + int'(first_hdr)));
      check("word_span", 64'(hs_cycles[hs_cycles.size()-1] - t0), 64'(10 * n - 1 + hdrs));
    end
  endtask

  task automatic applyStimulus();
    int bad;
    int prev_cnt;
    int c;
    int target;

    bus.fifo_full = 1'b0;
    bus.fifo_rd_data_cnt = 6'd0;
    applyReset();

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rd_clk);
      #3;
      if (bus.fifo_rd_en || bus.out_valid) bad++;
    end
    check("idle_empty_no_pop", 64'(bad), 64'd0);

    ready_mode = 0;
    timedRun(1, 1'b1);
    timedRun(3, 1'b0);

    ready_mode = 1;
    for (int i = 0; i < 2; i++) push_word(rand_word());
    drain();

    ready_mode = 2;
    glitch_en = 1;
    for (int i = 0; i < 6; i++) push_word(rand_word());
    drain();
    glitch_en = 0;

    // blk_ready threshold and one-cycle lag
    @(negedge rd_clk);
    bus.fifo_rd_data_cnt = 6'd15;
    repeat (2) @(negedge rd_clk);
    #3;
    check("blk_15", 64'(blk_ready), 64'd0);
    bus.fifo_rd_data_cnt = 6'd16;
    #1;
    check("blk_16_lag", 64'(blk_ready), 64'd0);
    @(negedge rd_clk);
    #3;
    check("blk_16", 64'(blk_ready), 64'd1);
    prev_cnt = 16;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      #3;
      check("blk_rand", 64'(blk_ready), 64'(prev_cnt >= THR));
      prev_cnt = $urandom_range(63);
      bus.fifo_rd_data_cnt = 6'(prev_cnt);
    end

    // Sticky overflow: set, hold, set-beats-clear, clear.
    @(negedge rd_clk);
    check("ovf_initial", 64'(ovf_sticky), 64'd0);
    bus.fifo_full = 1'b1;
    @(negedge rd_clk);
    bus.fifo_full = 1'b0;
    #3;
    check("ovf_set", 64'(ovf_sticky), 64'd1);
    repeat (3) @(negedge rd_clk);
    #3;
    check("ovf_hold", 64'(ovf_sticky), 64'd1);
    bus.fifo_full = 1'b1;
    clr_ovf = 1'b1;
    @(negedge rd_clk);
    bus.fifo_full = 1'b0;
    clr_ovf = 1'b0;
    #3;
    check("ovf_set_wins", 64'(ovf_sticky), 64'd1);
    clr_ovf = 1'b1;
    @(negedge rd_clk);
    clr_ovf = 1'b0;
    #3;
    check("ovf_clear", 64'(ovf_sticky), 64'd0);

    // Reset after the third payload slice of a word.
    ready_mode = 0;
    hs_cycles.delete();
    target = 3 + ((HDR_ON && (words_pushed % FW == 0)) ? 1 : 0);
    push_word(rand_word());
    c = 0;
    while (hs_cycles.size() < target && c < 100) begin
      @(negedge rd_clk);
      #5;
      c++;
    end
    check("midword_reached", 64'(hs_cycles.size()), 64'(target));
    applyReset();
    push_word(rand_word());
    drain();
    push_word(rand_word());
    drain();
  endtask

  task automatic checkOutput();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    bus.fifo_full = 1'b0;
    bus.fifo_rd_data_cnt = 6'd0;
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
